// File: rtl/opcode_dispatch.sv
// opcode_dispatch: opcode queue feeding a microsequencer label lookup.
// Fetched opcodes enter a DEPTH-entry FIFO and are consumed one per
// boundary cycle (mc__more == 0) unless the datapath is busy or a
// js_mode change is waiting to be applied.
// Optional feature: define OPCODE_DISPATCH_PERF_EN to build saturating
// issue/stall performance counters; otherwise both read as constant 0.
module opcode_dispatch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [7:0]  fetch_opcode,
  output logic        fetch_ready,
  input  logic        mode_req_valid,
  input  logic        mode_req_value,
  input  logic        dp_busy,
  input  logic        mc__more,
  output logic [7:0]  opcode,
  output logic        js_mode,
  output logic        mc__stall,
  output logic [4:0]  q_count,
  output logic        issue_pulse,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stalls
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_MODE
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          js_mode_q, js_mode_d;
  logic          pend_val_q, pend_val_d;
  state_t        state_q, state_d;

  logic boundary, empty, pending, push, pop, mode_commit;

  // Output view; during the reset cycle everything looks like an empty queue.
  always_comb begin
    boundary    = !mc__more;
    empty       = (count_q == '0);
    pending     = (state_q == S_MODE);
    fetch_ready = 1'b1;
    opcode      = NOP_OPCODE;
    js_mode     = 1'b0;
    q_count     = '0;
    mc__stall   = dp_busy || boundary;
    issue_pulse = 1'b0;
    if (!rst) begin
      fetch_ready = (count_q < 5'(DEPTH));
      opcode      = empty ? NOP_OPCODE : mem_q[rd_ptr_q];
      js_mode     = js_mode_q;
      q_count     = count_q;
      mc__stall   = dp_busy || (boundary && (empty || pending));
      issue_pulse = boundary && !mc__stall;
    end
  end

  // Queue bookkeeping, mode latch and FSM next state.
  always_comb begin
    push        = !rst && fetch_valid && fetch_ready;
    pop         = issue_pulse;
    mode_commit = !rst && pending && boundary && !dp_busy;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + {4'b0, push} - {4'b0, pop};
    js_mode_d   = mode_commit ? pend_val_q : js_mode_q;
    pend_val_d  = mode_req_valid ? mode_req_value : pend_val_q;
    // A new request while one is being applied re-arms MODE with the new value.
    if (mode_req_valid)
      state_d = S_MODE;
    else if (pending && !mode_commit)
      state_d = S_MODE;
    else if (mc__more)
      state_d = S_RUN;
    else if (count_d != '0)
      state_d = S_ISSUE;
    else
      state_d = S_IDLE;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      js_mode_q  <= 1'b0;
      pend_val_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      js_mode_q  <= js_mode_d;
      pend_val_q <= pend_val_d;
      state_q    <= state_d;
    end
  end

  // Queue storage; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= fetch_opcode;
  end

`ifdef OPCODE_DISPATCH_PERF_EN
  logic [15:0] perf_issued_q, perf_issued_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  // Saturating event counters.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stalls_d = perf_stalls_q;
    if (issue_pulse && (perf_issued_q != '1))
      perf_issued_d = perf_issued_q + 16'd1;
    if (mc__stall && (perf_stalls_q != '1))
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_issued = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_opcode_dispatch.sv
// Testbench for opcode_dispatch: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a scoreboard
// of accepted opcodes in push order.
module tb_opcode_dispatch;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  NOP   = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [7:0]  fetch_opcode;
  logic        fetch_ready;
  logic        mode_req_valid;
  logic        mode_req_value;
  logic        dp_busy;
  logic        mc__more;
  logic [7:0]  opcode;
  logic        js_mode;
  logic        mc__stall;
  logic [4:0]  q_count;
  logic        issue_pulse;
  logic [15:0] perf_issued;
  logic [15:0] perf_stalls;

  opcode_dispatch #(.DEPTH(DEPTH), .NOP_OPCODE(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_opcode(fetch_opcode), .fetch_ready(fetch_ready),
    .mode_req_valid(mode_req_valid), .mode_req_value(mode_req_value),
    .dp_busy(dp_busy), .mc__more(mc__more),
    .opcode(opcode), .js_mode(js_mode), .mc__stall(mc__stall),
    .q_count(q_count), .issue_pulse(issue_pulse),
    .perf_issued(perf_issued), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic       m_mode, m_pend, m_pval;
  int unsigned m_pi, m_ps;
  logic       e_ready, e_stall, e_issue, e_mode;
  logic [7:0] e_op;
  int unsigned e_cnt;

  initial begin
    m_mode = 1'b0; m_pend = 1'b0; m_pval = 1'b0; m_pi = 0; m_ps = 0;
  end

  // Monitor: predict outputs from the model, compare, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      e_ready = 1'b1; e_op = NOP; e_issue = 1'b0; e_cnt = 0; e_mode = 1'b0;
      e_stall = dp_busy || !mc__more;
    end else begin
      e_cnt   = mq.size();
      e_ready = (e_cnt < DEPTH);
      e_op    = (e_cnt != 0) ? mq[0] : NOP;
      e_mode  = m_mode;
      e_stall = dp_busy || (!mc__more && (e_cnt == 0 || m_pend));
      e_issue = !mc__more && !e_stall;
    end
    chk("fetch_ready", {15'b0, fetch_ready}, {15'b0, e_ready});
    chk("mc__stall",   {15'b0, mc__stall},   {15'b0, e_stall});
    chk("issue_pulse", {15'b0, issue_pulse}, {15'b0, e_issue});
    chk("q_count",     {11'b0, q_count},     16'(e_cnt));
    chk("opcode",      {8'b0, opcode},       {8'b0, e_op});
    chk("js_mode",     {15'b0, js_mode},     {15'b0, e_mode});
`ifdef OPCODE_DISPATCH_PERF_EN
    chk("perf_issued", perf_issued, 16'(m_pi));
    chk("perf_stalls", perf_stalls, 16'(m_ps));
`else
    chk("perf_issued", perf_issued, 16'h0000);
    chk("perf_stalls", perf_stalls, 16'h0000);
`endif
    // Scoreboard: every DUT issue must present the oldest accepted opcode.
    if (!rst && issue_pulse === 1'b1) begin
      chk("sb_has_entry", {15'b0, sb.size() != 0}, 16'h0001);
      if (sb.size() != 0) chk("sb_order", {8'b0, opcode}, {8'b0, sb.pop_front()});
    end
    // Advance model to the state after the coming rising edge.
    if (rst) begin
      mq.delete(); sb.delete();
      m_mode = 1'b0; m_pend = 1'b0; m_pval = 1'b0; m_pi = 0; m_ps = 0;
    end else begin
      if (e_issue) void'(mq.pop_front());
      if (!mc__more && m_pend && !dp_busy) begin
        m_mode = m_pval;
        m_pend = 1'b0;
      end
      if (mode_req_valid) begin
        m_pend = 1'b1;
        m_pval = mode_req_value;
      end
      if (fetch_valid && e_ready) begin
        mq.push_back(fetch_opcode);
        sb.push_back(fetch_opcode);
      end
      if (e_issue && m_pi < 16'hFFFF) m_pi++;
      if (e_stall && m_ps < 16'hFFFF) m_ps++;
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0; fetch_opcode = 8'h00; mode_req_valid = 1'b0;
    mode_req_value = 1'b0; dp_busy = 1'b0;
  endtask

  task automatic push_op(input logic [7:0] op);
    fetch_valid = 1'b1; fetch_opcode = op; step(1);
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mc__more = 1'b0; idle_inputs();
    step(2);
    rst = 1'b0;

    // Single push then immediate issue on boundary
    push_op(8'h12);
    step(3);

    // Fill beyond depth while sequencer is mid-microprogram, then drain
    mc__more = 1'b1;
    for (int unsigned i = 0; i < 5; i++) push_op(8'hA1 + 8'(i));
    step(1);
    mc__more = 1'b0;
    step(6);

    // Mode request while mc__more is high
    mc__more = 1'b1;
    push_op(8'h39);
    mode_req_valid = 1'b1; mode_req_value = 1'b1; step(1);
    mode_req_valid = 1'b0; step(1);
    mc__more = 1'b0;
    step(4);

    // Full queue, push attempt on the same cycle as a pop
    mc__more = 1'b1;
    for (int unsigned i = 0; i < 4; i++) push_op(8'h40 + 8'(i));
    mc__more = 1'b0;
    push_op(8'h4F);
    step(6);

    // Datapath busy on a boundary with queued work
    mc__more = 1'b1;
    push_op(8'h51); push_op(8'h52);
    mc__more = 1'b0; dp_busy = 1'b1;
    step(3);
    dp_busy = 1'b0;
    step(4);

    // Reset while queue holds work and a mode change is pending
    mc__more = 1'b1;
    push_op(8'h61); push_op(8'h62); push_op(8'h63);
    mode_req_valid = 1'b1; mode_req_value = 1'b0; step(1);
    mode_req_valid = 1'b0;
    rst = 1'b1; step(1);
    rst = 1'b0; mc__more = 1'b0;
    step(3);

    // Random traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      fetch_valid    = ($urandom_range(0, 9) < 6);
      fetch_opcode   = 8'($urandom);
      dp_busy        = ($urandom_range(0, 9) < 2);
      mode_req_valid = ($urandom_range(0, 19) == 0);
      mode_req_value = 1'($urandom);
      if ($urandom_range(0, 3) == 0) mc__more = 1'($urandom);
      rst            = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0; idle_inputs(); mc__more = 1'b0;
    step(8);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
